// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response type and bus widths
package axil_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/ram_1r1w.sv
// rtl/ram_1r1w.sv - DEPTH x 32 RAM, one synchronous read port, one byte-enabled write port, read-first
module ram_1r1w
  import axil_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [IDX_W-1:0]           waddr,
  input  logic [AXIL_STRB_WIDTH-1:0] wstrb,
  input  logic [AXIL_DATA_WIDTH-1:0] wdata,
  input  logic                       re,
  input  logic [IDX_W-1:0]           raddr,
  output logic [AXIL_DATA_WIDTH-1:0] rdata
);

  logic [AXIL_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AXIL_DATA_WIDTH-1:0] rdata_q;

  // No reset on purpose: contents and read register stay block-RAM inferable.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < AXIL_STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axil_ram.sv
// rtl/axil_ram.sv - AXI4-Lite slave over a word-addressed RAM; AXIL_RAM_OUTREG_EN adds a read output register
module axil_ram
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       s_axi_awready,
  input  logic                       s_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
  output logic                       s_axi_wready,
  input  logic                       s_axi_wvalid,
  input  logic [AXIL_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                       s_axi_bready,
  output logic                       s_axi_bvalid,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_arready,
  input  logic                       s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic                       s_axi_rready,
  output logic                       s_axi_rvalid,
  output logic [AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                 s_axi_rresp
);

  localparam int IDX_W = $clog2(DEPTH);

  logic                       rdy_en_q, rdy_en_d;
  logic                       aw_held_q, aw_held_d;
  logic [IDX_W-1:0]           aw_idx_q, aw_idx_d;
  logic                       aw_ok_q, aw_ok_d;
  logic                       w_held_q, w_held_d;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXIL_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                       bvalid_q, bvalid_d;
  resp_t                      bresp_q, bresp_d;
  logic                       rvalid_q, rvalid_d;
  resp_t                      rresp_q, rresp_d;

  logic                       aw_hs, w_hs, ar_hs, commit;
  logic                       aw_in_range, ar_in_range, wr_ok;
  logic [IDX_W-1:0]           wr_idx;
  logic [AXIL_DATA_WIDTH-1:0] wr_data, ram_rdata;
  logic [AXIL_STRB_WIDTH-1:0] wr_strb;
  logic                       unused_addr_lsbs;

  assign aw_in_range      = (s_axi_awaddr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign ar_in_range      = (s_axi_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = rdy_en_q & ~aw_held_q;
  assign s_axi_wready  = rdy_en_q & ~w_held_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Held registers are bypassed so a same-cycle AW+W commits without a bubble.
  always_comb begin
    wr_idx  = aw_held_q ? aw_idx_q : s_axi_awaddr[IDX_W+1:2];
    wr_ok   = aw_held_q ? aw_ok_q : aw_in_range;
    wr_data = w_held_q ? wdata_q : s_axi_wdata;
    wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & (~bvalid_q | s_axi_bready);

    rdy_en_d  = 1'b1;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q & ~s_axi_bready;
    bresp_d   = bresp_q;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? OKAY : SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = s_axi_awaddr[IDX_W+1:2];
        aw_ok_d   = aw_in_range;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = s_axi_wdata;
        wstrb_d  = s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      rdy_en_q  <= rdy_en_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  ram_1r1w #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (commit & wr_ok),
    .waddr (wr_idx),
    .wstrb (wr_strb),
    .wdata (wr_data),
    .re    (ar_hs),
    .raddr (s_axi_araddr[IDX_W+1:2]),
    .rdata (ram_rdata)
  );

`ifdef AXIL_RAM_OUTREG_EN
  logic                       rd_busy_q, rd_busy_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_ok_q, s1_ok_d;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                       r_hs;

  assign r_hs          = rvalid_q & s_axi_rready;
  assign s_axi_arready = rdy_en_q & ~rd_busy_q;
  assign s_axi_rdata   = rdata_q;

  always_comb begin
    rd_busy_d  = (rd_busy_q & ~r_hs) | ar_hs;
    s1_valid_d = ar_hs;
    s1_ok_d    = ar_hs ? ar_in_range : s1_ok_q;
    rvalid_d   = s1_valid_q | (rvalid_q & ~s_axi_rready);
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    if (s1_valid_q) begin
      rdata_d = s1_ok_q ? ram_rdata : '0;
      rresp_d = s1_ok_q ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_busy_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_ok_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_busy_q  <= rd_busy_d;
      s1_valid_q <= s1_valid_d;
      s1_ok_q    <= s1_ok_d;
      rdata_q    <= rdata_d;
    end
  end
`else
  logic rd_ok_q, rd_ok_d;

  // The RAM read register is the output stage; the in-range flag masks it to
  // zero for SLVERR beats and while nothing has been read since reset.
  assign s_axi_arready = rdy_en_q & (~rvalid_q | s_axi_rready);
  assign s_axi_rdata   = rd_ok_q ? ram_rdata : '0;

  always_comb begin
    rd_ok_d  = ar_hs ? ar_in_range : rd_ok_q;
    rvalid_d = ar_hs | (rvalid_q & ~s_axi_rready);
    rresp_d  = ar_hs ? (ar_in_range ? OKAY : SLVERR) : rresp_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_ok_q <= 1'b0;
    else        rd_ok_q <= rd_ok_d;
  end
`endif

endmodule

// File: tb/tb_axil_ram.sv
// tb/tb_axil_ram.sv - self-checking bench for axil_ram against a transaction-level memory model
module tb_axil_ram;

  localparam int AW    = 32;
  localparam int DEPTH = 1024;
`ifdef AXIL_RAM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_awready, s_axi_awvalid;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_wready, s_axi_wvalid;
  logic [3:0]  s_axi_wstrb;
  logic [31:0] s_axi_wdata;
  logic        s_axi_bready, s_axi_bvalid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arready, s_axi_arvalid;
  logic [31:0] s_axi_araddr;
  logic        s_axi_rready, s_axi_rvalid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  always #5 clk = ~clk;

  axil_ram #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awready(s_axi_awready), .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wready(s_axi_wready), .s_axi_wvalid(s_axi_wvalid), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wdata(s_axi_wdata), .s_axi_bready(s_axi_bready), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bresp(s_axi_bresp), .s_axi_arready(s_axi_arready), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_araddr(s_axi_araddr), .s_axi_rready(s_axi_rready), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: words live in an associative array, a write takes
  // effect once its B beat is accepted, reads are answered from the array.
  typedef struct { logic [31:0] data; logic [3:0] strb; } wd_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rd_t;

  logic [31:0] mem_m [int];
  logic [31:0] aw_fifo[$];
  wd_t         w_fifo[$];
  wr_t         pend_b[$];
  rd_t         exp_r[$];
  wr_t         cur_w;
  rd_t         cur_r, r_hold;
  logic        r_stall = 1'b0, b_stall = 1'b0;
  logic [1:0]  b_hold;

  function automatic bit in_range(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      aw_fifo.delete(); w_fifo.delete(); pend_b.delete(); exp_r.delete();
      r_stall = 1'b0; b_stall = 1'b0;
    end else begin
      if (r_stall) begin
        check("r_hold_valid", s_axi_rvalid, 1'b1);
        check("r_hold_data", s_axi_rdata, r_hold.data);
        check("r_hold_resp", s_axi_rresp, r_hold.resp);
      end
      if (b_stall) begin
        check("b_hold_valid", s_axi_bvalid, 1'b1);
        check("b_hold_resp", s_axi_bresp, b_hold);
      end
      r_stall = s_axi_rvalid && !s_axi_rready;
      r_hold.data = s_axi_rdata; r_hold.resp = s_axi_rresp;
      b_stall = s_axi_bvalid && !s_axi_bready;
      b_hold = s_axi_bresp;

      if (s_axi_bvalid && s_axi_bready) begin
        if (pend_b.size() == 0) check("b_unexpected", 1, 0);
        else begin
          cur_w = pend_b.pop_front();
          check("bresp", s_axi_bresp, in_range(cur_w.addr) ? 2'b00 : 2'b10);
          if (in_range(cur_w.addr))
            mem_m[cur_w.addr >> 2] = merge(mem_m.exists(cur_w.addr >> 2) ? mem_m[cur_w.addr >> 2] : 32'h0,
                                           cur_w.data, cur_w.strb);
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else begin
          cur_r = exp_r.pop_front();
          check("rdata", s_axi_rdata, cur_r.data);
          check("rresp", s_axi_rresp, cur_r.resp);
        end
      end
      if (s_axi_awvalid && s_axi_awready) aw_fifo.push_back(s_axi_awaddr);
      if (s_axi_wvalid && s_axi_wready) w_fifo.push_back('{s_axi_wdata, s_axi_wstrb});
      while (aw_fifo.size() > 0 && w_fifo.size() > 0) begin
        cur_w.addr = aw_fifo.pop_front();
        cur_w.data = w_fifo[0].data; cur_w.strb = w_fifo[0].strb;
        void'(w_fifo.pop_front());
        pend_b.push_back(cur_w);
      end
      if (s_axi_arvalid && s_axi_arready) begin
        if (in_range(s_axi_araddr)) begin
          cur_r.data = mem_m.exists(s_axi_araddr >> 2) ? mem_m[s_axi_araddr >> 2] : 32'h0;
          cur_r.resp = 2'b00;
        end else begin
          cur_r.data = 32'h0; cur_r.resp = 2'b10;
        end
        exp_r.push_back(cur_r);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit en_aw, input bit en_w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic af, wf;
    s_axi_awvalid = en_aw; s_axi_awaddr = a;
    s_axi_wvalid = en_w; s_axi_wdata = d; s_axi_wstrb = s;
    for (int c = 0; c < 50 && (s_axi_awvalid || s_axi_wvalid); c++) begin
      af = s_axi_awvalid && s_axi_awready;
      wf = s_axi_wvalid && s_axi_wready;
      step();
      if (af) s_axi_awvalid = 1'b0;
      if (wf) s_axi_wvalid = 1'b0;
    end
    if (s_axi_awvalid || s_axi_wvalid) begin
      check("send_timeout", 1, 0);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end
  endtask

  task automatic wait_b(output int lat, output logic [1:0] resp);
    lat = 1;
    while (!s_axi_bvalid && lat < 50) begin step(); lat++; end
    if (!s_axi_bvalid) check("b_timeout", 0, 1);
    resp = s_axi_bresp;
    step();
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int lat;
    send(1, 1, a, d, s);
    wait_b(lat, resp);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
    logic af;
    s_axi_arvalid = 1'b1; s_axi_araddr = a;
    for (int c = 0; c < 50 && s_axi_arvalid; c++) begin
      af = s_axi_arready;
      step();
      if (af) s_axi_arvalid = 1'b0;
    end
    if (s_axi_arvalid) begin check("ar_timeout", 1, 0); s_axi_arvalid = 1'b0; end
    lat = 1;
    while (!s_axi_rvalid && lat < 50) begin step(); lat++; end
    if (!s_axi_rvalid) check("r_timeout", 0, 1);
    d = s_axi_rdata; r = s_axi_rresp;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, beats, ar_n;
    logic        af, rf;

    reset = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_bready = 1; s_axi_rready = 1;
    repeat (3) step();
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rresp", s_axi_rresp, 0);
    reset = 1'b1;
    check("rel_arready_0", s_axi_arready, 0);
    step();
    check("rel_awready_1", s_axi_awready, 1);
    check("rel_wready_1", s_axi_wready, 1);
    check("rel_arready_1", s_axi_arready, 1);

    // basic write then read, with latencies
    send(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_b(lat, r);
    check("t1_bresp", r, 2'b00);
    check("t1_b_lat", lat, 1);
    do_read(32'h10, d, r, lat);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", r, 2'b00);
    check("t1_r_lat", lat, RD_LAT);

    // W three cycles ahead of AW
    send(0, 1, 32'h0, 32'h20202020, 4'hF);
    check("t2_wready_low", s_axi_wready, 0);
    repeat (3) step();
    check("t2_no_early_b", s_axi_bvalid, 0);
    send(1, 0, 32'h20, 32'h0, 4'h0);
    wait_b(lat, r);
    check("t2_b_lat", lat, 1);
    check("t2_bresp", r, 2'b00);
    do_read(32'h20, d, r, lat);
    check("t2_rdata", d, 32'h20202020);

    // partial strobe merge
    write(32'h50, 32'h11223344, 4'hF, r);
    write(32'h50, 32'hAABBCCDD, 4'h5, r);
    check("t3_bresp", r, 2'b00);
    do_read(32'h50, d, r, lat);
    check("t3_rdata", d, 32'h11BB33DD);
    check("t3_model", mem_m[20], 32'h11BB33DD);

    // out of range: no aliasing onto word 0
    write(32'h0, 32'h01234567, 4'hF, r);
    write(32'h1000, 32'hFFFFFFFF, 4'hF, r);
    check("t4_bresp_slverr", r, 2'b10);
    do_read(32'h0, d, r, lat);
    check("t4_word0_kept", d, 32'h01234567);
    do_read(32'h1000, d, r, lat);
    check("t4_rdata_zero", d, 32'h0);
    check("t4_rresp_slverr", r, 2'b10);

    // eight back-to-back reads with a 4-cycle rready stall
    for (int i = 0; i < 8; i++) write(32'h100 + 4 * i, 32'hA5000000 + i, 4'hF, r);
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h100; ar_n = 0; beats = 0;
    for (int c = 0; c < 100 && beats < 8; c++) begin
      s_axi_rready = !(c >= 3 && c < 7);
      #1;
      af = s_axi_arvalid && s_axi_arready;
      rf = s_axi_rvalid && s_axi_rready;
      step();
      if (rf) beats++;
      if (af) begin
        ar_n++;
        if (ar_n == 8) s_axi_arvalid = 1'b0;
        else s_axi_araddr = 32'h100 + 4 * ar_n;
      end
    end
    s_axi_rready = 1'b1;
    s_axi_arvalid = 1'b0;
    check("t5_beats", beats, 8);
    check("t5_queue_empty", exp_r.size(), 0);

    // reset with a pending B and a held write
    write(32'h30, 32'h30303030, 4'hF, r);
    s_axi_bready = 1'b0;
    send(1, 1, 32'h40, 32'h44444444, 4'hF);
    lat = 0;
    while (!s_axi_bvalid && lat < 20) begin step(); lat++; end
    send(1, 1, 32'h30, 32'hBADBAD00, 4'hF);
    check("t6_aw_held", s_axi_awready, 0);
    check("t6_bvalid_pending", s_axi_bvalid, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_awready", s_axi_awready, 0);
    check("t6_rst_wready", s_axi_wready, 0);
    check("t6_rst_arready", s_axi_arready, 0);
    check("t6_rst_bvalid", s_axi_bvalid, 0);
    check("t6_rst_bresp", s_axi_bresp, 0);
    check("t6_rst_rvalid", s_axi_rvalid, 0);
    check("t6_rst_rdata", s_axi_rdata, 0);
    check("t6_rst_rresp", s_axi_rresp, 0);
    s_axi_bready = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    check("t6_rel_arready_0", s_axi_arready, 0);
    step();
    check("t6_rel_awready_1", s_axi_awready, 1);
    check("t6_rel_wready_1", s_axi_wready, 1);
    check("t6_rel_arready_1", s_axi_arready, 1);
    check("t6_no_bvalid", s_axi_bvalid, 0);
    do_read(32'h30, d, r, lat);
    check("t6_held_write_lost", d, 32'h30303030);

    repeat (3) step();
    check("end_b_queue", pend_b.size(), 0);
    check("end_r_queue", exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_ram.md
# axil_ram

AXI4-Lite slave (responder) exposing a word-addressed on-chip RAM. It provides the memory target on the DMA engine's master read and write ports, which otherwise have no target on the SOC. Reads and writes are served independently, with single-cycle read latency by default. Out-of-range accesses return SLVERR.

## Interface
Parameters:
- ADDR_WIDTH, 32: byte-address width of awaddr/araddr.
- DEPTH, 1024: number of 32-bit words; must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- s_axi_awready  output  1  write-address ready.
- s_axi_awvalid  input  1  write-address valid.
- s_axi_awaddr  input  ADDR_WIDTH  write byte address.
- s_axi_wready  output  1  write-data ready.
- s_axi_wvalid  input  1  write-data valid.
- s_axi_wstrb  input  4  byte enables.
- s_axi_wdata  input  32  write data.
- s_axi_bready  input  1  response ready.
- s_axi_bvalid  output  1  response valid.
- s_axi_bresp  output  2  write response.
- s_axi_arready  output  1  read-address ready.
- s_axi_arvalid  input  1  read-address valid.
- s_axi_araddr  input  ADDR_WIDTH  read byte address.
- s_axi_rready  input  1  read-data ready.
- s_axi_rvalid  output  1  read-data valid.
- s_axi_rdata  output  32  read data.
- s_axi_rresp  output  2  read response.

## Operation
- Address decode: word index = addr[$clog2(DEPTH)+1:2]. addr[1:0] is ignored. The access is in range when addr[ADDR_WIDTH-1:$clog2(DEPTH)+2] == 0.
- rdy_en flop: resets to 0 and goes to 1 on the first clk edge after reset deasserts. All readies are gated by rdy_en.
- Write path:
  - State: aw_held flag with address register, and w_held flag with data/strobe register.
  - awready = rdy_en & ~aw_held.
  - wready = rdy_en & ~w_held.
  - AW and W may handshake in either order or in the same cycle.
- Write commit: occurs on the edge where an address and data are both available (held, or handshaking this cycle) and (~bvalid | bready).
  - In range: bytes with wstrb=1 are written; bresp = OKAY (2'b00).
  - Out of range: no write; bresp = SLVERR (2'b10).
  - bvalid is set at the commit edge. aw_held and w_held are cleared, or bypassed if the handshake and commit happen in the same cycle.
- bvalid holds, with bresp stable, until bready is sampled high.
- Read path (default):
  - arready = rdy_en & (~rvalid | rready), giving full-throughput back-to-back reads.
  - On an AR handshake, rdata/rresp load at the next edge and rvalid is set.
  - Out of range: rdata = 0, rresp = SLVERR.
  - rvalid clears on rready when no new AR handshake occurs in the same cycle.
- Read and write to the same word on the same edge: read-first. rdata returns the old contents.
- Memory contents are not reset.
- Reset values: awready=0, wready=0, arready=0, bvalid=0, bresp=0, rvalid=0, rdata=0, rresp=0.
- Reset mid-transaction: held address/data, bvalid and rvalid are discarded. Any write whose commit edge has not occurred is lost.

## Timing
- Write response: bvalid is high the cycle after the later of the AW and W handshakes, provided no earlier B response is pending. Minimum 1 cycle.
- Read latency: rvalid is high the cycle after the AR handshake.
- Sustained rates: one read per cycle, and one write per cycle when AW and W are presented together and bready=1.
- No combinational path from any input valid to any output ready.

## Configuration
- AXIL_RAM_OUTREG_EN defined:
  - An extra output register stage sits after the RAM; read latency is 2 cycles.
  - Only one read may be in flight: arready = rdy_en & ~rd_busy.
  - rd_busy is set on the AR handshake and cleared on the R handshake.
- AXIL_RAM_OUTREG_EN undefined: 1-cycle pipelined read path as described under Operation.

## Structure
- Shared package axil_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - AXIL_DATA_WIDTH=32.
  - AXIL_STRB_WIDTH=4.
- Sub-module ram_1r1w (DEPTH × 32):
  - one synchronous read port and one byte-enabled write port;
  - read-first behaviour;
  - inferable as block RAM.

## Test plan
- Write 0xDEADBEEF to addr 0x10, wstrb=0xF, then read 0x10: bresp=OKAY; rdata=0xDEADBEEF with rresp=OKAY; rvalid 1 cycle after the AR handshake (2 cycles with OUTREG_EN).
- W presented 3 cycles before AW at addr 0x20: wready drops after the W handshake. bvalid rises the cycle after the AW handshake. Readback matches.
- Word holds 0x11223344; write 0xAABBCCDD with wstrb=0x5: readback = 0x11BB33DD.
- Write to addr DEPTH*4 (0x1000 at default DEPTH): bresp=SLVERR and memory is unchanged. Read at 0x1000: rresp=SLVERR, rdata=0.
- Eight back-to-back reads with rready held low for 4 cycles mid-burst: no beat is lost or duplicated, and rdata is stable while stalled.
- Assert reset while bvalid=1 and an AW is held: all outputs return to 0. After release, ready outputs are 1 one cycle later. The held write is never performed.
